// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch block: FSM states, word width, buffer entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inst_fetch_pkg;

    localparam int WORD_W = 16;

    // Fetch FSM: IDLE decides, REQ handshakes address, WAIT takes data, DROP discards it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic fetch_entry_t mk_entry(input logic [WORD_W-1:0] pc,
                                              input logic [WORD_W-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer FIFO holding {pc, instr} entries between fetch and decode.
// Latency: one cycle from push to head visible; head is combinational from storage.
// Backpressure: caller guarantees no push when full and no pop when empty; flush wins over both.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Next pointer/count: flush empties, otherwise a simultaneous push and pop cancel in the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while not counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head reads zero when empty so the decode-side bus is quiet after reset and flush.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory read at a time into a BUF_DEPTH-entry buffer for decode.
// Latency: pc_in captured in IDLE, >=1 cycle gnt, >=1 cycle rvalid, +1 to id_valid (0 with INST_FETCH_BYPASS_EN).
// Backpressure: new fetch only when buffered + outstanding < BUF_DEPTH; id_ready=0 stalls the PC via pc_adv.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2  // 2 or 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] pc_in,
    output logic              pc_adv,
    input  logic              redirect,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    input  logic              id_ready
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              kill_q, kill_d;

    logic              fetch_go;
    logic              resp_take;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    fetch_entry_t      fifo_head;

    // Credit check: in IDLE nothing is outstanding, so the buffer count alone bounds new fetches.
    assign fetch_go = (state_q == IDLE) && !redirect && (fifo_count < DEPTH_C);

    // Next-state logic: a redirect poisons any fetch already issued, the response is then discarded.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        kill_d    = kill_q;
        resp_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_go) begin
                    state_d = REQ;
                    addr_d  = pc_in;
                end
            end
            REQ: begin
                if (redirect) kill_d = 1'b1;
                if (imem_gnt) state_d = (kill_q || redirect) ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    state_d   = IDLE;
                    resp_take = 1'b1;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, fetch address and kill flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
        end
    end

`ifdef INST_FETCH_BYPASS_EN
    // A response that would land in an empty buffer and be popped at once goes straight to decode.
    assign bypass = resp_take && fifo_empty && id_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_take && !bypass;
    assign pop  = !fifo_empty && id_ready;

    inst_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_i    (redirect),
        .push_i     (push),
        .push_dat_i (mk_entry(addr_q, imem_rdata)),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // pc_adv is qualified by reset so the PC never moves while the block is held in reset.
    assign pc_adv    = fetch_go && reset_n;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = addr_q;
    assign id_valid  = !fifo_empty || bypass;
    assign id_instr  = bypass ? imem_rdata : fifo_head.instr;
    assign id_pc     = bypass ? addr_q     : fifo_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam int DEPTH = 2;
`ifdef INST_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc_in;
    logic        pc_adv;
    logic        redirect;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_ready;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit mem_pend = 1'b0;

    always #5 clk = ~clk;

    inst_fetch #(.BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_adv      (pc_adv),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // A fetch is "in flight" from the cycle pc_in is taken until its response arrives.
    // It is "granted" once memory accepted it, and "killed" if a redirect hit it.
    bit          m_out, m_gnt, m_kill;
    logic [15:0] m_addr;
    logic [31:0] m_q[$];   // {pc, instr}, oldest first

    function automatic bit m_byp();
        return BYP && m_out && m_gnt && !m_kill && imem_rvalid && !redirect
               && (m_q.size() == 0) && id_ready;
    endfunction

    function automatic bit m_adv();
        return reset_n && !m_out && !redirect && (m_q.size() < DEPTH);
    endfunction

    initial begin
        m_out = 0; m_gnt = 0; m_kill = 0; m_addr = '0;
    end

    always @(posedge clk) begin
        bit byp, adv, deliver;
        if (!reset_n) begin
            m_out = 0; m_gnt = 0; m_kill = 0; m_addr = '0;
            m_q.delete();
        end else begin
            byp     = m_byp();
            adv     = m_adv();
            deliver = m_out && m_gnt && imem_rvalid && !m_kill && !redirect;
            if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
            if (redirect) m_q.delete();
            if (adv) begin
                m_out = 1; m_gnt = 0; m_kill = 0; m_addr = pc_in;
            end else if (m_out && !m_gnt) begin
                if (redirect) m_kill = 1;
                if (imem_gnt) m_gnt = 1;
            end else if (m_out) begin
                if (imem_rvalid) begin
                    if (deliver && !byp) m_q.push_back({m_addr, imem_rdata});
                    m_out = 0; m_gnt = 0; m_kill = 0;
                end else if (redirect) begin
                    m_kill = 1;
                end
            end
        end
    end

    // Memory side bookkeeping: one granted read awaits one response.
    always @(posedge clk) begin
        if (imem_rvalid)                mem_pend <= 1'b0;
        else if (imem_gnt && imem_req)  mem_pend <= 1'b1;
    end

    // ---------------- compare process ----------------
    logic [31:0] e_head;
    logic        e_valid;
    logic [15:0] e_instr, e_pc;

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            e_valid = 1'b0; e_instr = '0; e_pc = '0;
            if (m_q.size() > 0) begin
                e_head  = m_q[0];
                e_valid = 1'b1;
                e_pc    = e_head[31:16];
                e_instr = e_head[15:0];
            end else if (m_byp()) begin
                e_valid = 1'b1;
                e_pc    = m_addr;
                e_instr = imem_rdata;
            end
            chk("m_pc_adv",   pc_adv,    m_adv());
            chk("m_imem_req", imem_req,  m_out && !m_gnt);
            chk("m_imem_addr",imem_addr, m_addr);
            chk("m_id_valid", id_valid,  e_valid);
            chk("m_id_instr", id_instr,  e_instr);
            chk("m_id_pc",    id_pc,     e_pc);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 0; pc_in = '0; redirect = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = '0; id_ready = 0;
        @(posedge clk); @(posedge clk);
        chk_en = 1'b1;

        // Reset state
        @(negedge clk); #2;
        chk("rst_req", imem_req, 0);  chk("rst_addr", imem_addr, 0);
        chk("rst_adv", pc_adv, 0);    chk("rst_valid", id_valid, 0);
        chk("rst_instr", id_instr, 0); chk("rst_pc", id_pc, 0);

        // Test 1: basic fetch
        @(negedge clk); reset_n = 1; pc_in = 16'h0000; #2;
        chk("t1_adv", pc_adv, 1);
        @(negedge clk); pc_in = 16'h0010; imem_gnt = 1; #2;
        chk("t1_req", imem_req, 1); chk("t1_addr", imem_addr, 16'h0000);
        @(negedge clk); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 16'h1234; #2;
        chk("t1_novalid", id_valid, 0);
        @(negedge clk); imem_rvalid = 0; #2;
        chk("t1_valid", id_valid, 1); chk("t1_instr", id_instr, 16'h1234);
        chk("t1_pc", id_pc, 16'h0000); chk("t1_adv2", pc_adv, 1);

        // Test 2: full buffer stalls fetch
        @(negedge clk); imem_gnt = 1; pc_in = 16'h0020; #2;
        @(negedge clk); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 16'h5678; #2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); imem_rvalid = 0; #2;
            chk("t2_req_stall", imem_req, 0); chk("t2_adv_stall", pc_adv, 0);
            chk("t2_head", id_instr, 16'h1234);
        end
        @(negedge clk); id_ready = 1; #2;
        chk("t2_adv_popcyc", pc_adv, 0);
        @(negedge clk); id_ready = 0; pc_in = 16'h0005; #2;
        chk("t2_adv_resume", pc_adv, 1); chk("t2_instr2", id_instr, 16'h5678);
        chk("t2_pc2", id_pc, 16'h0010);

        // Test 3: redirect in WAIT
        @(negedge clk); imem_gnt = 1; #2;
        chk("t3_addr", imem_addr, 16'h0005);
        @(negedge clk); imem_gnt = 0; redirect = 1; pc_in = 16'h0040; #2;
        chk("t3_adv_redir", pc_adv, 0); chk("t3_valid_redir", id_valid, 1);
        @(negedge clk); redirect = 0; imem_rvalid = 1; imem_rdata = 16'hDEAD; #2;
        chk("t3_flushed", id_valid, 0);
        @(negedge clk); imem_rvalid = 0; #2;
        chk("t3_nodead", id_valid, 0); chk("t3_adv", pc_adv, 1);
        @(negedge clk); #2;
        chk("t3_req", imem_req, 1); chk("t3_newaddr", imem_addr, 16'h0040);

        // Test 4: redirect in REQ, grant late
        @(negedge clk); redirect = 1; pc_in = 16'h0080; #2;
        chk("t4_addr0", imem_addr, 16'h0040);
        @(negedge clk); redirect = 0; #2;
        chk("t4_addr1", imem_addr, 16'h0040); chk("t4_req1", imem_req, 1);
        @(negedge clk); imem_gnt = 1; #2;
        chk("t4_addr2", imem_addr, 16'h0040); chk("t4_req2", imem_req, 1);
        @(negedge clk); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 16'hBEEF; #2;
        chk("t4_drop_valid", id_valid, 0); chk("t4_drop_req", imem_req, 0);
        @(negedge clk); imem_rvalid = 0; #2;
        chk("t4_idle_adv", pc_adv, 1); chk("t4_novalid", id_valid, 0);

        // Test 5: reset during WAIT, stale response
        @(negedge clk); imem_gnt = 1; #2;
        chk("t5_addr", imem_addr, 16'h0080);
        @(negedge clk); imem_gnt = 0; reset_n = 0; #2;
        @(negedge clk); imem_rvalid = 1; imem_rdata = 16'h9999; #2;
        chk("t5_req", imem_req, 0);  chk("t5_addr0", imem_addr, 0);
        chk("t5_adv", pc_adv, 0);    chk("t5_valid", id_valid, 0);
        chk("t5_instr", id_instr, 0); chk("t5_pc", id_pc, 0);
        @(negedge clk); reset_n = 1; pc_in = 16'h0100; #2;
        chk("t5_stale_valid", id_valid, 0); chk("t5_adv_rel", pc_adv, 1);
        @(negedge clk); imem_rvalid = 0; #2;
        chk("t5_still_empty", id_valid, 0); chk("t5_newaddr", imem_addr, 16'h0100);

        // Test 6: bypass vs buffered latency
        @(negedge clk); imem_gnt = 1; id_ready = 1; #2;
        @(negedge clk); imem_gnt = 0; imem_rvalid = 1; imem_rdata = 16'h7F00; #2;
        chk("t6_valid_same", id_valid, BYP);
        if (BYP) begin
            chk("t6_instr_same", id_instr, 16'h7F00); chk("t6_pc_same", id_pc, 16'h0100);
        end
        @(negedge clk); imem_rvalid = 0; #2;
        chk("t6_valid_next", id_valid, !BYP);
        if (!BYP) begin
            chk("t6_instr_next", id_instr, 16'h7F00); chk("t6_pc_next", id_pc, 16'h0100);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset_n     = ($urandom_range(0, 399) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            pc_in       = 16'($urandom);
            id_ready    = ($urandom_range(0, 2) != 0);
            imem_gnt    = imem_req && !mem_pend && ($urandom_range(0, 1) == 1);
            imem_rvalid = mem_pend && ($urandom_range(0, 2) != 0);
            imem_rdata  = 16'($urandom);
            #2;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries; legal values 2 or 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port pc_in, input, 16 bits: fetch address from the PC stage.
REQ-005 SHALL have port pc_adv, output, 1 bit: one-cycle pulse telling the PC stage that pc_in was consumed and the PC may advance.
REQ-006 SHALL have port redirect, input, 1 bit: the PC took a BEQ or JALR target; discard all younger fetches.
REQ-007 SHALL have ports imem_req (output, 1), imem_addr (output, 16) and imem_gnt (input, 1): memory read request handshake.
REQ-008 SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 16): memory read response.
REQ-009 SHALL have ports id_valid (output, 1), id_instr (output, 16), id_pc (output, 16) and id_ready (input, 1): valid/ready handoff to decode.

Function
REQ-010 SHALL run an FSM with states IDLE, REQ, WAIT and DROP, and SHALL allow at most one outstanding memory request.
REQ-011 IDLE->REQ SHALL occur when redirect=0 and (buffer count + outstanding) < BUF_DEPTH; in that cycle it SHALL capture pc_in into imem_addr and pulse pc_adv.
REQ-012 In REQ, imem_req=1 and imem_addr SHALL hold stable until imem_gnt=1; on imem_gnt it SHALL go to WAIT, or to DROP if the kill flag is set.
REQ-013 In WAIT, imem_rvalid=1 SHALL push {imem_addr, imem_rdata} into the buffer and return to IDLE.
REQ-014 In DROP, imem_rvalid=1 SHALL discard the data, clear the kill flag and return to IDLE.
REQ-015 redirect=1 SHALL empty the buffer in the same edge and SHALL deassert id_valid from the next cycle; redirect in WAIT SHALL move to DROP; redirect in REQ SHALL set the kill flag.
REQ-016 While redirect=1 the block SHALL NOT pulse pc_adv; the first fetch after a redirect SHALL use pc_in from the following cycle, which is the new target.
REQ-017 The buffer SHALL be a FIFO: id_valid = not empty; the head is shown on id_instr/id_pc; it SHALL pop when id_valid && id_ready.
REQ-018 A push and a pop in the same cycle SHALL leave the count unchanged; pushing into a full buffer is impossible by the credit rule of REQ-011.
REQ-019 If redirect and rvalid arrive in the same cycle in WAIT, the response SHALL be dropped and the FSM SHALL go to IDLE.
REQ-020 Buffer pointers SHALL wrap modulo BUF_DEPTH; the count SHALL be $clog2(BUF_DEPTH)+1 bits wide.

Reset
REQ-021 reset_n=0 at a rising edge SHALL set FSM=IDLE, count=0, both pointers=0, kill=0, imem_req=0, imem_addr=0, pc_adv=0, id_valid=0, id_instr=0 and id_pc=0.
REQ-022 Reset during WAIT SHALL abandon the request; a stale imem_rvalid arriving after reset SHALL be ignored while in IDLE.

Configuration
REQ-023 With the macro INST_FETCH_BYPASS_EN defined, a response arriving when the buffer is empty and id_ready=1 SHALL appear on id_valid/id_instr/id_pc in the same cycle without being written into the buffer.
REQ-024 Without INST_FETCH_BYPASS_EN, every response SHALL be written into the buffer first, giving at least one cycle of latency from imem_rvalid to id_valid.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (2 bits), the 16-bit word-width constant and the fetch-entry struct {pc, instr}.
REQ-026 The FIFO SHALL be a sub-module named inst_fetch_fifo.

Verification
REQ-027 Test 1: reset, then pc_in=0x0000, gnt the cycle after req, rvalid one cycle later with rdata=0x1234 -> id_valid=1, id_instr=0x1234, id_pc=0x0000.
REQ-028 Test 2: id_ready=0 held with BUF_DEPTH=2 -> after two fetches, imem_req stays 0 and pc_adv does not pulse until id_ready=1.
REQ-029 Test 3: redirect in WAIT with addr 0x0005, then rvalid with rdata=0xDEAD -> 0xDEAD is never presented; the next request uses imem_addr=0x0040 (pc_in=0x0040).
REQ-030 Test 4: redirect in REQ with imem_gnt held low for 3 cycles -> imem_addr stays stable, the response after gnt is dropped, and the FSM returns to IDLE.
REQ-031 Test 5: reset_n=0 in WAIT, then imem_rvalid=1 -> all outputs read zero and the buffer stays empty.
REQ-032 Test 6: with INST_FETCH_BYPASS_EN, buffer empty and id_ready=1, rvalid with rdata=0x7F00 -> id_valid=1 in the same cycle; without the macro, id_valid=1 one cycle later.
